// File: rtl/riscv_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_lite_pkg
//  Purpose  : Shared types and constants for the writeback stage: result
//             source select encoding and load funct3 codes.
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_lite_pkg;

    // Writeback source select; the fourth code is reserved and never writes.
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wbsel_t;

    // Load funct3 encodings.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // True when a load of this type cannot be served from this address.
    // Unknown funct3 values are handled as full-word loads.
    function automatic logic load_misaligned(input logic [2:0] funct3,
                                             input logic [1:0] addr_lsb);
        logic mis;
        case (funct3)
            F3_LB, F3_LBU: mis = 1'b0;
            F3_LH, F3_LHU: mis = addr_lsb[0];
            default:       mis = (addr_lsb != 2'b00);
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_unit_load_formatter.sv
`default_nettype none
// ============================================================================
//  Module   : load_formatter
//  Purpose  : Combinational load formatting. Picks the byte/halfword lane
//             from an aligned memory word, sign- or zero-extends it, and
//             flags misaligned halfword/word accesses.
//  Revision : 1.0 - initial release
// ============================================================================
module load_formatter
    import riscv_lite_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic [2:0]       i_funct3,
    input  logic [1:0]       i_addr_lsb,
    input  logic [NBITS-1:0] i_raw,
    output logic [NBITS-1:0] o_data,
    output logic             o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection followed by extension according to the load type.
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_data = '0;

        case (i_addr_lsb)
            2'd0:    w_byte = i_raw[7:0];
            2'd1:    w_byte = i_raw[15:8];
            2'd2:    w_byte = i_raw[23:16];
            default: w_byte = i_raw[31:24];
        endcase
        w_half = i_addr_lsb[1] ? i_raw[31:16] : i_raw[15:0];

        case (i_funct3)
            F3_LB:   o_data = {{(NBITS-8){w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {{(NBITS-8){1'b0}}, w_byte};
            F3_LH:   o_data = {{(NBITS-16){w_half[15]}}, w_half};
            F3_LHU:  o_data = {{(NBITS-16){1'b0}}, w_half};
            default: o_data = i_raw;
        endcase
    end

    assign o_misalign = load_misaligned(i_funct3, i_addr_lsb);

endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_unit
//  Purpose  : Writeback stage. Captures MEM results into the WB register,
//             drives the register file write port exactly once per
//             instruction, and keeps a destination-register busy scoreboard
//             that decode uses for RAW hazard detection.
//  Revision : 1.0 - initial release
// ============================================================================
module writeback_unit
    import riscv_lite_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int NREGISTERS = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STALL,
    input  logic             MEM_VALID,
    input  logic             MEM_REGWRITE,
    input  logic [4:0]       MEM_RD,
    input  logic [1:0]       MEM_WBSEL,
    input  logic [2:0]       MEM_FUNCT3,
    input  logic [1:0]       MEM_ADDR_LSB,
    input  logic [NBITS-1:0] MEM_ALU_RES,
    input  logic [NBITS-1:0] MEM_LOAD_DATA,
    input  logic [NBITS-1:0] MEM_PC4,
    input  logic             ISSUE_VALID,
    input  logic [4:0]       ISSUE_RD,
    input  logic [4:0]       CHK_RS1,
    input  logic [4:0]       CHK_RS2,
    output logic             RF_WR,
    output logic [4:0]       RF_ADD_WR,
    output logic [NBITS-1:0] RF_DATAIN,
    output logic             HAZARD,
    output logic             LOAD_MISALIGN
);

    logic [NBITS-1:0]      w_fmt_data;
    logic                  w_fmt_misalign;
    logic [NBITS-1:0]      w_sel_data;
    logic                  w_complete;

    // WB pipeline register. regwrite marks an instruction that owns a busy
    // bit; we additionally excludes the reserved source select.
    logic                  r_wb_valid_q,    w_wb_valid_d;
    logic                  r_wb_regwrite_q, w_wb_regwrite_d;
    logic                  r_wb_we_q,       w_wb_we_d;
    logic                  r_wb_misalign_q, w_wb_misalign_d;
    logic [4:0]            r_wb_rd_q,       w_wb_rd_d;
    logic [NBITS-1:0]      r_wb_data_q,     w_wb_data_d;
    logic                  r_wb_done_q,     w_wb_done_d;
    logic [NREGISTERS-1:0] r_busy_q,        w_busy_d;

    load_formatter #(
        .NBITS (NBITS)
    ) u_load_formatter (
        .i_funct3   (MEM_FUNCT3),
        .i_addr_lsb (MEM_ADDR_LSB),
        .i_raw      (MEM_LOAD_DATA),
        .o_data     (w_fmt_data),
        .o_misalign (w_fmt_misalign)
    );

    // Result source multiplexer feeding the WB register.
    always_comb begin
        w_sel_data = '0;
        case (wbsel_t'(MEM_WBSEL))
            WB_ALU:  w_sel_data = MEM_ALU_RES;
            WB_LOAD: w_sel_data = w_fmt_data;
            WB_PC4:  w_sel_data = MEM_PC4;
            default: w_sel_data = '0;
        endcase
    end

    // The completion cycle is when the held instruction retires: it writes,
    // or would have written if not misaligned/reserved. It fires only once
    // per instruction because wb_done latches right after it.
    assign w_complete    = r_wb_valid_q & r_wb_regwrite_q & (r_wb_rd_q != 5'd0) & ~r_wb_done_q;
    assign RF_WR         = w_complete & r_wb_we_q & ~r_wb_misalign_q;
    assign LOAD_MISALIGN = w_complete & r_wb_misalign_q;
    assign RF_ADD_WR     = r_wb_valid_q ? r_wb_rd_q   : 5'd0;
    assign RF_DATAIN     = r_wb_valid_q ? r_wb_data_q : '0;
    assign HAZARD        = r_busy_q[CHK_RS1] | r_busy_q[CHK_RS2];

    // Next state of the WB register: capture, drain to invalid, or hold.
    always_comb begin
        w_wb_valid_d    = r_wb_valid_q;
        w_wb_regwrite_d = r_wb_regwrite_q;
        w_wb_we_d       = r_wb_we_q;
        w_wb_misalign_d = r_wb_misalign_q;
        w_wb_rd_d       = r_wb_rd_q;
        w_wb_data_d     = r_wb_data_q;
        w_wb_done_d     = r_wb_done_q;

        if (!STALL) begin
            w_wb_done_d = 1'b0;
            if (MEM_VALID) begin
                w_wb_valid_d    = 1'b1;
                w_wb_regwrite_d = MEM_REGWRITE;
                w_wb_we_d       = MEM_REGWRITE & (MEM_WBSEL != WB_RSVD);
                w_wb_misalign_d = (MEM_WBSEL == WB_LOAD) & w_fmt_misalign;
                w_wb_rd_d       = MEM_RD;
                w_wb_data_d     = w_sel_data;
            end else begin
                w_wb_valid_d    = 1'b0;
                w_wb_regwrite_d = 1'b0;
                w_wb_we_d       = 1'b0;
                w_wb_misalign_d = 1'b0;
            end
        end else if (w_complete) begin
            w_wb_done_d = 1'b1;
        end
    end

    // Scoreboard update: clear on completion, then set on issue so a
    // same-cycle set of the same register wins. x0 is never busy.
    always_comb begin
        w_busy_d = r_busy_q;
        if (w_complete) begin
            w_busy_d[r_wb_rd_q] = 1'b0;
        end
        if (ISSUE_VALID && (ISSUE_RD != 5'd0)) begin
            w_busy_d[ISSUE_RD] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    // State registers with synchronous reset; reset discards pending writes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wb_valid_q    <= 1'b0;
            r_wb_regwrite_q <= 1'b0;
            r_wb_we_q       <= 1'b0;
            r_wb_misalign_q <= 1'b0;
            r_wb_rd_q       <= 5'd0;
            r_wb_data_q     <= '0;
            r_wb_done_q     <= 1'b0;
            r_busy_q        <= '0;
        end else begin
            r_wb_valid_q    <= w_wb_valid_d;
            r_wb_regwrite_q <= w_wb_regwrite_d;
            r_wb_we_q       <= w_wb_we_d;
            r_wb_misalign_q <= w_wb_misalign_d;
            r_wb_rd_q       <= w_wb_rd_d;
            r_wb_data_q     <= w_wb_data_d;
            r_wb_done_q     <= w_wb_done_d;
            r_busy_q        <= w_busy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_writeback_unit
//  Purpose  : Self-checking bench for writeback_unit: directed scenarios and
//             a randomized run against an instruction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;

    logic        CLK = 1'b0;
    logic        RESET, STALL, MEM_VALID, MEM_REGWRITE;
    logic [4:0]  MEM_RD;
    logic [1:0]  MEM_WBSEL;
    logic [2:0]  MEM_FUNCT3;
    logic [1:0]  MEM_ADDR_LSB;
    logic [31:0] MEM_ALU_RES, MEM_LOAD_DATA, MEM_PC4;
    logic        ISSUE_VALID;
    logic [4:0]  ISSUE_RD, CHK_RS1, CHK_RS2;
    logic        RF_WR, HAZARD, LOAD_MISALIGN;
    logic [4:0]  RF_ADD_WR;
    logic [31:0] RF_DATAIN;

    int checks   = 0;
    int failures = 0;

    // Reference model: the instruction sitting in writeback and whether it
    // still owes its one retirement, plus a per-register busy set.
    logic        m_valid, m_pending, m_mis, m_res;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_busy [32];

    writeback_unit #(.NBITS(32), .NREGISTERS(32)) dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .MEM_VALID(MEM_VALID),
        .MEM_REGWRITE(MEM_REGWRITE), .MEM_RD(MEM_RD), .MEM_WBSEL(MEM_WBSEL),
        .MEM_FUNCT3(MEM_FUNCT3), .MEM_ADDR_LSB(MEM_ADDR_LSB),
        .MEM_ALU_RES(MEM_ALU_RES), .MEM_LOAD_DATA(MEM_LOAD_DATA), .MEM_PC4(MEM_PC4),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD), .CHK_RS1(CHK_RS1), .CHK_RS2(CHK_RS2),
        .RF_WR(RF_WR), .RF_ADD_WR(RF_ADD_WR), .RF_DATAIN(RF_DATAIN),
        .HAZARD(HAZARD), .LOAD_MISALIGN(LOAD_MISALIGN)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lsb,
                                             input logic [31:0] raw);
        logic [31:0] b, h;
        int sh;
        sh = 8 * int'(lsb);
        b  = (raw >> sh) & 32'hFF;
        h  = (raw >> (16 * int'(lsb[1]))) & 32'hFFFF;
        case (f3)
            3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return raw;
        endcase
    endfunction

    function automatic logic ref_mis(input logic [2:0] f3, input logic [1:0] lsb);
        if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
        if (f3 == 3'b001 || f3 == 3'b101) return (lsb % 2) != 0;
        return lsb != 2'd0;
    endfunction

    task automatic model_update();
        if (RESET) begin
            m_valid = 0; m_pending = 0; m_mis = 0; m_res = 0; m_rd = 0; m_data = 0;
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
        end else begin
            if (m_pending) begin
                m_busy[m_rd] = 0;
                m_pending = 0;
            end
            if (ISSUE_VALID && ISSUE_RD != 0) m_busy[ISSUE_RD] = 1;
            if (!STALL) begin
                if (MEM_VALID) begin
                    m_valid   = 1;
                    m_rd      = MEM_RD;
                    m_pending = MEM_REGWRITE && (MEM_RD != 0);
                    m_res     = (MEM_WBSEL == 2'd3);
                    m_mis     = (MEM_WBSEL == 2'd1) && ref_mis(MEM_FUNCT3, MEM_ADDR_LSB);
                    case (MEM_WBSEL)
                        2'd0:    m_data = MEM_ALU_RES;
                        2'd1:    m_data = ref_load(MEM_FUNCT3, MEM_ADDR_LSB, MEM_LOAD_DATA);
                        2'd2:    m_data = MEM_PC4;
                        default: m_data = 0;
                    endcase
                end else begin
                    m_valid = 0;
                    m_pending = 0;
                end
            end
        end
    endtask

    // One clock: model follows the same edge the DUT sees, inputs may
    // change 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        STALL = 0; MEM_VALID = 0; MEM_REGWRITE = 0; MEM_RD = 0; MEM_WBSEL = 0;
        MEM_FUNCT3 = 0; MEM_ADDR_LSB = 0; MEM_ALU_RES = 0; MEM_LOAD_DATA = 0;
        MEM_PC4 = 0; ISSUE_VALID = 0; ISSUE_RD = 0; CHK_RS1 = 0; CHK_RS2 = 0;
    endtask

    task automatic mem_op(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                          input logic [1:0] lsb, input logic [31:0] alu, input logic [31:0] raw);
        MEM_VALID = 1; MEM_REGWRITE = 1; MEM_RD = rd; MEM_WBSEL = sel; MEM_FUNCT3 = f3;
        MEM_ADDR_LSB = lsb; MEM_ALU_RES = alu; MEM_LOAD_DATA = raw; MEM_PC4 = 32'h0000_0104;
    endtask

    task automatic test_reset();
        clear_inputs();
        RESET = 1;
        tick(); tick();
        RESET = 0;
        #1;
        checks++;
        if (RF_WR !== 1'b0 || RF_ADD_WR !== 5'd0 || RF_DATAIN !== 32'd0 ||
            HAZARD !== 1'b0 || LOAD_MISALIGN !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got wr=%b add=%0d data=%h haz=%b mis=%b required all zero",
                     RF_WR, RF_ADD_WR, RF_DATAIN, HAZARD, LOAD_MISALIGN);
        end
    endtask

    task automatic test_alu_write();
        clear_inputs();
        mem_op(5'd5, 2'b00, 3'b000, 2'd0, 32'h0000_1234, 32'h0);
        tick();
        MEM_VALID = 0;
        #1;
        checks++;
        if (RF_WR !== 1'b1 || RF_ADD_WR !== 5'd5 || RF_DATAIN !== 32'h0000_1234) begin
            failures++;
            $display("FAIL alu_write: got wr=%b add=%0d data=%h required wr=1 add=5 data=00001234",
                     RF_WR, RF_ADD_WR, RF_DATAIN);
        end
        tick();
        checks++;
        if (RF_WR !== 1'b0) begin
            failures++;
            $display("FAIL alu_write_after: got wr=%b required 0", RF_WR);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [1:0]  lsb [4] = '{2'd2, 2'd3, 2'd2, 2'd0};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            mem_op(5'd10 + 5'(i), 2'b01, f3[i], lsb[i], 32'h0, 32'h80FF_7F01);
            tick();
            MEM_VALID = 0;
            #1;
            checks++;
            if (RF_WR !== 1'b1 || RF_DATAIN !== exp[i] || LOAD_MISALIGN !== 1'b0) begin
                failures++;
                $display("FAIL load_format[%0d]: got wr=%b data=%h mis=%b required wr=1 data=%h mis=0",
                         i, RF_WR, RF_DATAIN, LOAD_MISALIGN, exp[i]);
            end
        end
        tick();
    endtask

    task automatic test_misalign();
        clear_inputs();
        ISSUE_VALID = 1; ISSUE_RD = 5'd7;
        tick();
        ISSUE_VALID = 0; CHK_RS1 = 5'd7;
        mem_op(5'd7, 2'b01, 3'b010, 2'd1, 32'h0, 32'hDEAD_BEEF);
        tick();
        MEM_VALID = 0;
        #1;
        checks++;
        if (RF_WR !== 1'b0 || LOAD_MISALIGN !== 1'b1 || HAZARD !== 1'b1) begin
            failures++;
            $display("FAIL misalign_pulse: got wr=%b mis=%b haz=%b required wr=0 mis=1 haz=1",
                     RF_WR, LOAD_MISALIGN, HAZARD);
        end
        tick();
        checks++;
        if (LOAD_MISALIGN !== 1'b0 || HAZARD !== 1'b0 || RF_WR !== 1'b0) begin
            failures++;
            $display("FAIL misalign_after: got mis=%b haz=%b wr=%b required 0 0 0",
                     LOAD_MISALIGN, HAZARD, RF_WR);
        end
    endtask

    task automatic test_x0_stall();
        int wr_count;
        clear_inputs();
        mem_op(5'd0, 2'b00, 3'b000, 2'd0, 32'hFFFF_FFFF, 32'h0);
        tick();
        MEM_VALID = 0;
        #1;
        checks++;
        if (RF_WR !== 1'b0) begin
            failures++;
            $display("FAIL x0_write: got wr=%b required 0", RF_WR);
        end
        mem_op(5'd9, 2'b10, 3'b000, 2'd0, 32'h0, 32'h0);
        tick();
        MEM_VALID = 0; STALL = 1;
        wr_count = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) STALL = 0;
            #1;
            if (RF_WR === 1'b1) wr_count++;
            checks++;
            if (RF_ADD_WR !== 5'd9 || RF_DATAIN !== 32'h0000_0104) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got add=%0d data=%h required add=9 data=00000104",
                         c, RF_ADD_WR, RF_DATAIN);
            end
            tick();
        end
        checks++;
        if (wr_count !== 1) begin
            failures++;
            $display("FAIL stall_single_write: got %0d write cycles required 1", wr_count);
        end
    endtask

    task automatic test_scoreboard();
        clear_inputs();
        ISSUE_VALID = 1; ISSUE_RD = 5'd3;
        tick();
        ISSUE_VALID = 0; CHK_RS1 = 5'd3; CHK_RS2 = 5'd0;
        #1;
        checks++;
        if (HAZARD !== 1'b1) begin
            failures++;
            $display("FAIL sb_set: got haz=%b required 1", HAZARD);
        end
        mem_op(5'd3, 2'b00, 3'b000, 2'd0, 32'h33, 32'h0);
        tick();
        MEM_VALID = 0;
        #1;
        checks++;
        if (HAZARD !== 1'b1 || RF_WR !== 1'b1) begin
            failures++;
            $display("FAIL sb_busy_during_write: got haz=%b wr=%b required 1 1", HAZARD, RF_WR);
        end
        tick();
        checks++;
        if (HAZARD !== 1'b0) begin
            failures++;
            $display("FAIL sb_clear: got haz=%b required 0", HAZARD);
        end
        // Set and clear of the same register in one cycle.
        ISSUE_VALID = 1; ISSUE_RD = 5'd3;
        tick();
        ISSUE_VALID = 0;
        mem_op(5'd3, 2'b00, 3'b000, 2'd0, 32'h44, 32'h0);
        tick();
        MEM_VALID = 0; ISSUE_VALID = 1; ISSUE_RD = 5'd3;
        tick();
        ISSUE_VALID = 0;
        #1;
        checks++;
        if (HAZARD !== 1'b1) begin
            failures++;
            $display("FAIL sb_set_wins: got haz=%b required 1", HAZARD);
        end
        mem_op(5'd3, 2'b00, 3'b000, 2'd0, 32'h55, 32'h0);
        tick();
        MEM_VALID = 0;
        tick();
    endtask

    task automatic test_reset_midflight();
        clear_inputs();
        ISSUE_VALID = 1; ISSUE_RD = 5'd4;
        tick();
        ISSUE_VALID = 0; CHK_RS1 = 5'd4;
        mem_op(5'd4, 2'b00, 3'b000, 2'd0, 32'hCAFE_0004, 32'h0);
        tick();
        MEM_VALID = 0; RESET = 1;
        tick();
        RESET = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (RF_WR !== 1'b0 || RF_ADD_WR !== 5'd0 || RF_DATAIN !== 32'd0 ||
                HAZARD !== 1'b0 || LOAD_MISALIGN !== 1'b0) begin
                failures++;
                $display("FAIL reset_midflight[%0d]: got wr=%b add=%0d data=%h haz=%b mis=%b required all zero",
                         c, RF_WR, RF_ADD_WR, RF_DATAIN, HAZARD, LOAD_MISALIGN);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic e_wr, e_mis, e_haz;
        logic [4:0]  e_add;
        logic [31:0] e_data;
        for (int n = 0; n < 400; n++) begin
            RESET         = ($urandom_range(0, 59) == 0);
            STALL         = ($urandom_range(0, 3) == 0);
            MEM_VALID     = ($urandom_range(0, 3) != 0);
            MEM_REGWRITE  = ($urandom_range(0, 4) != 0);
            MEM_RD        = 5'($urandom_range(0, 7));
            MEM_WBSEL     = 2'($urandom_range(0, 3));
            MEM_FUNCT3    = 3'($urandom_range(0, 7));
            MEM_ADDR_LSB  = 2'($urandom_range(0, 3));
            MEM_ALU_RES   = $urandom;
            MEM_LOAD_DATA = $urandom;
            MEM_PC4       = $urandom;
            ISSUE_VALID   = ($urandom_range(0, 2) == 0);
            ISSUE_RD      = 5'($urandom_range(0, 7));
            CHK_RS1       = 5'($urandom_range(0, 7));
            CHK_RS2       = 5'($urandom_range(0, 7));
            #1;
            e_wr   = m_pending && !m_mis && !m_res;
            e_mis  = m_pending && m_mis;
            e_haz  = m_busy[CHK_RS1] || m_busy[CHK_RS2];
            e_add  = m_valid ? m_rd : 5'd0;
            e_data = m_valid ? m_data : 32'd0;
            checks++;
            if (RF_WR !== e_wr || LOAD_MISALIGN !== e_mis || HAZARD !== e_haz) begin
                failures++;
                $display("FAIL rand_ctrl[%0d]: got wr=%b mis=%b haz=%b required wr=%b mis=%b haz=%b",
                         n, RF_WR, LOAD_MISALIGN, HAZARD, e_wr, e_mis, e_haz);
            end
            checks++;
            if (RF_ADD_WR !== e_add) begin
                failures++;
                $display("FAIL rand_addr[%0d]: got %0d required %0d", n, RF_ADD_WR, e_add);
            end
            if (!(m_valid && (m_mis || m_res))) begin
                checks++;
                if (RF_DATAIN !== e_data) begin
                    failures++;
                    $display("FAIL rand_data[%0d]: got %h required %h", n, RF_DATAIN, e_data);
                end
            end
            tick();
        end
    endtask

    initial begin
        RESET = 1;
        clear_inputs();
        test_reset();
        test_alu_write();
        test_loads();
        test_misalign();
        test_x0_stall();
        test_scoreboard();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
